// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative HI/LO multiply/divide unit (shift-add multiply,
//             restoring divide, one bit per cycle) with MTHI/MTLO and abort.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;
  localparam logic [COUNT_W-1:0] c_LAST = COUNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_next_state;
  logic [COUNT_W-1:0]   r_count;
  logic [WIDTH-1:0]     r_acc, r_mq, r_mcand, r_hi, r_lo;
  logic                 r_is_div, r_neg_q, r_neg_r, r_done, r_div0;

  logic                 w_accept, w_is_mul, w_is_div, w_div_zero, w_start_run;
  logic                 w_signed, w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
  logic [WIDTH:0]       w_mul_sum, w_div_shift, w_div_diff;
  logic [2*WIDTH-1:0]   w_prod, w_prod_fix;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand decode and magnitude extraction, used only on the accepting edge
  always_comb begin
    w_accept    = start & ~busy & ~abort;
    w_is_mul    = (op == c_OP_MULT) | (op == c_OP_MULTU);
    w_is_div    = (op == c_OP_DIV)  | (op == c_OP_DIVU);
    w_div_zero  = w_is_div & (rt_val == '0);
    w_start_run = w_accept & (w_is_mul | (w_is_div & ~w_div_zero));
    w_signed    = (op == c_OP_MULT) | (op == c_OP_DIV);
    w_rs_neg    = w_signed & rs_val[WIDTH-1];
    w_rt_neg    = w_signed & rt_val[WIDTH-1];
    w_rs_mag    = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
    w_rt_mag    = w_rt_neg ? (~rt_val + 1'b1) : rt_val;
  end

  // One iteration of each algorithm; the remainder stays below the divisor,
  // so the shifted partial remainder always fits in WIDTH+1 bits.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
    w_div_shift = {r_acc, r_mq[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_mcand};
    w_prod      = {r_acc, r_mq};
    w_prod_fix  = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_next_state = S_RUN;
      S_RUN: begin
        if (abort)                 w_next_state = S_IDLE;
        else if (r_count == c_LAST) w_next_state = S_FIX;
      end
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_count <= (r_state == S_RUN && !abort) ? r_count + COUNT_W'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (w_start_run) begin
            r_acc    <= '0;
            r_mq     <= w_rs_mag;
            r_mcand  <= w_rt_mag;
            r_is_div <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
          end else if (w_accept && w_div_zero) begin
            r_done <= 1'b1;
            r_div0 <= 1'b1;
          end else if (w_accept && op == c_OP_MTHI) begin
            r_hi <= rs_val;
          end else if (w_accept && op == c_OP_MTLO) begin
            r_lo <= rs_val;
          end
        end
        S_RUN: begin
          if (!abort) begin
            if (r_is_div) begin
              if (!w_div_diff[WIDTH]) begin
                r_acc <= w_div_diff[WIDTH-1:0];
                r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
              end else begin
                r_acc <= w_div_shift[WIDTH-1:0];
                r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_acc <= w_mul_sum[WIDTH:1];
              r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!abort) begin
            if (r_is_div) begin
              r_lo <= r_neg_q ? (~r_mq + 1'b1) : r_mq;
              r_hi <= r_neg_r ? (~r_acc + 1'b1) : r_acc;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Scoreboard bench for muldiv_unit (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         abort = 1'b0;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  exp_t         scb[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           n_vec = 0;
  int           n_err = 0;

  muldiv_unit #(.WIDTH(W), .COUNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .abort(abort), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    int sa, sbv;
    e.hi = m_hi; e.lo = m_lo; e.div0 = 1'b0;
    case (o)
      3'd0: begin p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}; {e.hi, e.lo} = p; end
      3'd1: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b};     {e.hi, e.lo} = p; end
      3'd2: begin
        if (b == '0) e.div0 = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.lo = a; e.hi = '0; end
        else begin sa = a; sbv = b; e.lo = sa / sbv; e.hi = sa % sbv; end
      end
      3'd3: begin
        if (b == '0) e.div0 = 1'b1;
        else begin e.lo = a / b; e.hi = a % b; end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(o, a, b);
    scb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Drives one start pulse; returns #1 after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, input bit now_);
    if (!now_) begin @(posedge CLK); #1; end
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (track) push_exp(o, a, b);
    @(posedge CLK); #1;
    start = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic collect(output int bc, output bit got, output bit d0, output bit bsy);
    bc = 0; got = 1'b0; d0 = 1'b0; bsy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (done) begin got = 1'b1; d0 = div0; bsy = busy; break; end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if ({done, div0} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {done, div0}); end
    n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    RST = 1'b0;
  endtask

  task automatic test_arith();
    logic [2:0]   ops [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0, 3'd2};
    logic [W-1:0] as  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000,
                              32'h0000_0007, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs  [8] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF,
                              32'hFFFF_FFFE, 32'h0000_1234, 32'h8000_0000, 32'h0000_0003};
    int bc; bit got, d0, bsy; exp_t e;
    for (int i = 0; i < 14; i++) begin
      logic [2:0] o; logic [W-1:0] a, b;
      if (i < 8) begin o = ops[i]; a = as[i]; b = bs[i]; end
      else begin
        o = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        if (b == '0) b = 32'd1;
      end
      issue(o, a, b, 1'b1, 1'b0);
      collect(bc, got, d0, bsy);
      e = scb.pop_front();
      n_vec++; if (!got) begin n_err++; $display("FAIL arith%0d_done got none want pulse", i); end
      n_vec++; if (bc != 33) begin n_err++; $display("FAIL arith%0d_busy_cycles got %0d want 33", i, bc); end
      n_vec++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++;
        $display("FAIL arith%0d_hilo op=%0d got %h_%h want %h_%h", i, o, hi, lo, e.hi, e.lo); end
      n_vec++; if ({d0, bsy} !== 2'b00) begin n_err++; $display("FAIL arith%0d_div0_busy got %b want 00", i, {d0, bsy}); end
    end
  endtask

  task automatic test_div0();
    int bc; bit got, d0, bsy; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(3'd4, 32'hA5A5_0000 + k, '0, 1'b1, 1'b0); e = scb.pop_front();
      issue(k == 0 ? 3'd3 : 3'd2, 32'h1234_0000 + k, '0, 1'b1, 1'b0);
      collect(bc, got, d0, bsy);
      e = scb.pop_front();
      n_vec++; if (!got || bc != 0 || bsy) begin n_err++;
        $display("FAIL div0_%0d_timing got done=%b busy_cycles=%0d busy=%b want 1/0/0", k, got, bc, bsy); end
      n_vec++; if (d0 !== e.div0) begin n_err++; $display("FAIL div0_%0d_flag got %b want %b", k, d0, e.div0); end
      n_vec++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++;
        $display("FAIL div0_%0d_hilo got %h want %h", k, {hi, lo}, {e.hi, e.lo}); end
      @(negedge CLK);
      n_vec++; if ({done, div0, busy} !== 3'b000) begin n_err++;
        $display("FAIL div0_%0d_pulse got %b want 000", k, {done, div0, busy}); end
    end
  endtask

  task automatic test_mthi_mtlo();
    exp_t e1, e2;
    @(posedge CLK); #1;
    start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678; push_exp(3'd4, rs_val, '0);
    @(posedge CLK); #1;
    op = 3'd5; rs_val = 32'h9ABC_DEF0; push_exp(3'd5, rs_val, '0);
    @(negedge CLK);
    e1 = scb.pop_front();
    n_vec++; if (hi !== e1.hi || {done, busy} !== 2'b00) begin n_err++;
      $display("FAIL mthi got hi=%h done/busy=%b want %h/00", hi, {done, busy}, e1.hi); end
    @(posedge CLK); #1; start = 1'b0;
    @(negedge CLK);
    e2 = scb.pop_front();
    n_vec++; if ({hi, lo} !== {e2.hi, e2.lo} || {done, busy} !== 2'b00) begin n_err++;
      $display("FAIL mtlo got %h_%h done/busy=%b want %h_%h/00", hi, lo, {done, busy}, e2.hi, e2.lo); end
    issue(3'd6, 32'hFFFF_0000, 32'h1, 1'b1, 1'b0);
    @(negedge CLK);
    e1 = scb.pop_front();
    n_vec++; if ({hi, lo} !== {e1.hi, e1.lo} || {done, busy} !== 2'b00) begin n_err++;
      $display("FAIL noop got %h_%h done/busy=%b want %h_%h/00", hi, lo, {done, busy}, e1.hi, e1.lo); end
  endtask

  task automatic test_busy_ignored();
    int bc; bit got, d0, bsy, spurious; exp_t e;
    issue(3'd0, 32'h0001_0003, 32'hFFFF_FFF0, 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge CLK); #1; start = 1'b0;
    collect(bc, got, d0, bsy);
    e = scb.pop_front();
    n_vec++; if (!got || {hi, lo} !== {e.hi, e.lo}) begin n_err++;
      $display("FAIL busy_ignore got done=%b %h want %h", got, {hi, lo}, {e.hi, e.lo}); end
    spurious = 1'b0;
    repeat (40) begin @(negedge CLK); if (busy || done) spurious = 1'b1; end
    n_vec++; if (spurious) begin n_err++; $display("FAIL busy_ignore_extra got activity want none"); end
  endtask

  task automatic test_abort();
    int bc; bit got, d0, bsy, spurious; exp_t e;
    issue(3'd3, 32'hCAFE_F00D, 32'h0000_0101, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    abort = 1'b1;
    @(posedge CLK); #1; abort = 1'b0;
    @(negedge CLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    spurious = 1'b0;
    repeat (40) begin @(negedge CLK); if (busy || done) spurious = 1'b1; end
    n_vec++; if (spurious || {hi, lo} !== {m_hi, m_lo}) begin n_err++;
      $display("FAIL abort_hold got act=%b %h want 0 %h", spurious, {hi, lo}, {m_hi, m_lo}); end
    @(negedge CLK);
    start = 1'b1; abort = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge CLK); #1; start = 1'b0; abort = 1'b0;
    spurious = 1'b0;
    repeat (40) begin @(negedge CLK); if (busy || done) spurious = 1'b1; end
    n_vec++; if (spurious) begin n_err++; $display("FAIL abort_idle got activity want none"); end
    issue(3'd3, 32'hCAFE_F00D, 32'h0000_0101, 1'b1, 1'b0);
    collect(bc, got, d0, bsy);
    e = scb.pop_front();
    n_vec++; if (!got || {hi, lo} !== {e.hi, e.lo}) begin n_err++;
      $display("FAIL abort_next got done=%b %h want %h", got, {hi, lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_reset_mid();
    int bc; bit got, d0, bsy; exp_t e;
    issue(3'd0, 32'h7777_7777, 32'h3333_3333, 1'b0, 1'b0);
    repeat (7) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    n_vec++; if ({busy, done, div0} !== 3'b000 || {hi, lo} !== 64'h0) begin n_err++;
      $display("FAIL rst_mid got busy/done/div0=%b hilo=%h want 000 0", {busy, done, div0}, {hi, lo}); end
    m_hi = '0; m_lo = '0;
    @(negedge CLK);
    RST = 1'b0;
    start = 1'b1; op = 3'd1; rs_val = 32'h0000_FFFF; rt_val = 32'h0001_0001;
    push_exp(3'd1, rs_val, rt_val);
    @(posedge CLK); #1; start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    collect(bc, got, d0, bsy);
    e = scb.pop_front();
    n_vec++; if (!got || bc != 33 || {hi, lo} !== {e.hi, e.lo}) begin n_err++;
      $display("FAIL rst_first_accept got done=%b cyc=%0d %h want 1 33 %h", got, bc, {hi, lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_back_to_back();
    int bc; bit got, d0, bsy; exp_t e;
    issue(3'd2, 32'hFFFF_FF00, 32'h0000_0007, 1'b1, 1'b0);
    collect(bc, got, d0, bsy);
    e = scb.pop_front();
    n_vec++; if (!got || bsy || {hi, lo} !== {e.hi, e.lo}) begin n_err++;
      $display("FAIL b2b_first got done=%b busy=%b %h want 1 0 %h", got, bsy, {hi, lo}, {e.hi, e.lo}); end
    issue(3'd1, 32'h89AB_CDEF, 32'h0000_0010, 1'b1, 1'b1);
    collect(bc, got, d0, bsy);
    e = scb.pop_front();
    n_vec++; if (!got || bc != 33 || {hi, lo} !== {e.hi, e.lo}) begin n_err++;
      $display("FAIL b2b_second got done=%b cyc=%0d %h want 1 33 %h", got, bc, {hi, lo}, {e.hi, e.lo}); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div0();
    test_mthi_mtlo();
    test_busy_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width in bits (even, >=8).
REQ-002 Parameter: COUNT_W, default 6, iteration counter width; must satisfy 2**COUNT_W > WIDTH.
REQ-003 Ports: CLK  in  1  single clock, all state on rising edge.
REQ-004 Ports: RST  in  1  reset, asynchronous, active-high.
REQ-005 Ports: start  in  1  request; accepted only when busy=0.
REQ-006 Ports: op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 Ports: rs_val  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
REQ-008 Ports: rt_val  in  WIDTH  multiplier / divisor.
REQ-009 Ports: abort  in  1  cancels an in-flight multiply/divide.
REQ-010 Ports: busy  out  1  high while a multiply/divide is in flight.
REQ-011 Ports: done  out  1  one-cycle pulse when HI/LO are updated by a multiply/divide.
REQ-012 Ports: div0  out  1  one-cycle pulse, with done, for a DIV/DIVU with rt_val=0.
REQ-013 Ports: hi  out  WIDTH  HI register; lo  out  WIDTH  LO register.

Function
REQ-014 FSM states IDLE, RUN, FIX; busy = (state != IDLE), combinational from state.
REQ-015 Accept = start & busy=0 & abort=0; start while busy or with abort=1 is ignored.
REQ-016 Accepted op 0-3 with nonzero divisor (or any mult): latch operand magnitudes (signed ops) or raw values (unsigned), record result signs, counter=0, IDLE->RUN.
REQ-017 RUN: one bit per cycle (shift-add multiply, restoring divide); exactly WIDTH cycles, then ->FIX.
REQ-018 FIX: apply sign correction, write HI/LO, set done=1 for the following cycle, ->IDLE; hi/lo new values visible from edge N+WIDTH+1 (N = accepting edge).
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH product; signed product negated iff operand signs differ.
REQ-020 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder; signed remainder takes dividend's sign.
REQ-021 DIV of most-negative by -1: lo = most-negative (wraps), hi = 0; no flag.
REQ-022 DIV/DIVU with rt_val=0: no RUN; hi/lo unchanged; done=1 and div0=1 for the cycle after the accepting edge; busy stays 0.
REQ-023 MTHI/MTLO: hi (resp. lo) <= rs_val on the accepting edge; no busy, no done.
REQ-024 op 6-7: accepted as no-op, no state change.
REQ-025 abort=1 while busy: ->IDLE on next edge; hi/lo unchanged; no done; counter cleared.
REQ-026 abort while IDLE has no effect other than blocking acceptance.
REQ-027 Operand inputs are sampled only on the accepting edge; later changes have no effect.
REQ-028 done and div0 are registered outputs, never high simultaneously with busy=1 from a new op in the same cycle except back-to-back acceptance is allowed on the done cycle.

Reset
REQ-029 RST=1 asynchronously forces state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div0=0, including mid-operation; no partial result written.
REQ-030 First accept possible on the first rising edge with RST=0.

Verification
REQ-031 WIDTH=32, MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 33 cycles, done at N+34 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU rt=0 -> done=div0=1 next cycle, hi/lo unchanged, busy never 1.
REQ-034 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo hold those values, no done; start during busy -> ignored, result matches first op.
REQ-035 Abort at cycle 10 of a DIVU, and RST pulse mid-MULT -> busy drops, no done, hi/lo unchanged (abort) / zero (reset); next op completes correctly.
